// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory segmentation port between instruction fetch and data memory.
// Blocks illegal accesses, bounds data-over-fetch starvation and counts contention cycles.
module mem_port_arbiter #(
   parameter int unsigned ROM_END    = 735,
   parameter int unsigned IO_ADDR    = 33135,
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [31:0]      if_addr,
   output logic             if_gnt,
   output logic             if_valid,
   output logic [31:0]      if_rdata,
   output logic             if_err,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [31:0]      dm_addr,
   input  logic [31:0]      dm_wd,
   output logic             dm_gnt,
   output logic             dm_valid,
   output logic [31:0]      dm_rdata,
   output logic             dm_err,
   output logic [31:0]      mem_addr,
   output logic             mem_we,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int unsigned SW = $clog2(MAX_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   logic [SW-1:0]    streak_q;
   logic             if_valid_q, if_err_q, dm_valid_q, dm_err_q;
   logic [31:0]      if_rdata_q, dm_rdata_q;
   logic [CNT_W-1:0] conflict_q;

   logic if_bad, dm_high, dm_bad;

   assign if_bad  = (if_addr >= ROM_END);
   assign dm_high = (dm_addr > IO_ADDR);
   assign dm_bad  = dm_high || (dm_we && (dm_addr < ROM_END));

   // Data wins ties unless the fetch has already waited MAX_STREAK data grants.
   always_comb begin
      if_gnt   = 1'b0;
      dm_gnt   = 1'b0;
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_wd   = '0;
      if (rst) begin
         if (dm_req && !(if_req && (streak_q == STREAK_MAX))) begin
            dm_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
         if (dm_gnt) begin
            mem_addr = dm_high ? '0 : dm_addr;
            mem_we   = dm_we && !dm_bad;
            mem_wd   = dm_wd;
         end else if (if_gnt) begin
            mem_addr = if_bad ? '0 : if_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak_q   <= '0;
         if_valid_q <= 1'b0;
         if_err_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_valid_q <= 1'b0;
         dm_err_q   <= 1'b0;
         dm_rdata_q <= '0;
         conflict_q <= '0;
      end else begin
         if_valid_q <= if_gnt;
         if_err_q   <= if_gnt && if_bad;
         if (if_gnt) begin
            if_rdata_q <= if_bad ? '0 : mem_rd;
         end
         dm_valid_q <= dm_gnt;
         dm_err_q   <= dm_gnt && dm_bad;
         if (dm_gnt) begin
            dm_rdata_q <= (dm_we || dm_high) ? '0 : mem_rd;
         end
         if (!if_req || if_gnt) begin
            streak_q <= '0;
         end else if (dm_gnt && (streak_q != STREAK_MAX)) begin
            streak_q <= streak_q + 1'b1;
         end
         if (if_req && dm_req && (conflict_q != '1)) begin
            conflict_q <= conflict_q + 1'b1;
         end
      end
   end

   assign if_valid     = if_valid_q;
   assign if_err       = if_err_q;
   assign if_rdata     = if_rdata_q;
   assign dm_valid     = dm_valid_q;
   assign dm_err       = dm_err_q;
   assign dm_rdata     = dm_rdata_q;
   assign conflict_cnt = conflict_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single address/data port of the memory segmentation block (ROM 0..734, RAM 735..33134, I/O word at 33135) between the pipeline's instruction-fetch stage and its data-memory stage.
- Arbitrates each cycle and drives the memory port. Registers read data back to the winning requester and returns one-cycle valid/err pulses.
- Blocks illegal accesses, bounds data-over-fetch starvation, and counts contention cycles.

Parameters:
ROM_END, 735, first non-instruction address; stores below it are illegal, fetches at or above it are illegal.
IO_ADDR, 33135, highest legal data address (switch read / GPIO write word).
MAX_STREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through.
CNT_W, 16, width of the contention counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  32  fetch address
if_gnt  out  1  fetch granted this cycle (combinational)
if_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  registered fetch data
if_err  out  1  pulse with if_valid: fetch address >= ROM_END
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wd until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  32  data address
dm_wd  in  32  store data
dm_gnt  out  1  data granted this cycle (combinational)
dm_valid  out  1  one-cycle pulse, load data / store completion
dm_rdata  out  32  registered load data (0 for stores)
dm_err  out  1  pulse with dm_valid: illegal data access
mem_addr  out  32  to memory segmentation address
mem_we  out  1  to memory segmentation we
mem_wd  out  32  to memory segmentation wd
mem_rd  in  32  from memory segmentation rd (combinational read)
conflict_cnt  out  CNT_W  saturating count of cycles with if_req and dm_req both high

Behaviour:
- Reset (rst=0, async): if_valid, dm_valid, if_err, dm_err, if_rdata, dm_rdata, streak, conflict_cnt all 0. While rst=0, if_gnt=dm_gnt=0 and mem_we=0, mem_addr=0, mem_wd=0. A request in flight when reset asserts is dropped with no valid pulse.
- Grant, combinational, at most one per cycle:
  - only dm_req: data.
  - only if_req: fetch.
  - both: data, unless streak==MAX_STREAK, then fetch.
  - neither: no grant, mem_addr=0, mem_we=0.
- streak register, 0..MAX_STREAK:
  - +1 on each cycle data is granted while if_req=1.
  - cleared when fetch is granted or if_req=0.
  - never exceeds MAX_STREAK.
- Port drive:
  - fetch winner: mem_addr=if_addr, mem_we=0, mem_wd=0.
  - data winner: mem_addr=dm_addr, mem_wd=dm_wd, mem_we=dm_we, subject to the legality rules below.
- Latency: the grant cycle samples mem_rd at the rising edge. The winner's rdata and valid update at that edge, so valid is high exactly one cycle after gnt. Back-to-back grants give one response per cycle.
- Legality, checked in the grant cycle; err is registered alongside valid:
  - Fetch with if_addr >= ROM_END: mem_addr=0; if_rdata<=0, if_err=1.
  - Store with dm_addr < ROM_END: mem_we forced 0; dm_err=1.
  - Any data access with dm_addr > IO_ADDR: mem_addr=0, mem_we=0; dm_rdata<=0, dm_err=1.
  - Load or store at IO_ADDR is legal and passes through unchanged.
- dm_rdata <= mem_rd for legal loads and 0 for stores. if_rdata/dm_rdata hold their value when not being written.
- conflict_cnt: +1 per cycle with if_req&&dm_req; saturates at all-ones.
- The arbiter has no queue. Requesters must hold their request until gnt; dropping req before gnt is legal and costs nothing.

Test Plan:
1. Reset release, if_req=1, if_addr=4, ROM[4]=0x00A00513 -> if_gnt same cycle, next cycle if_valid=1, if_rdata=0x00A00513, if_err=0.
2. dm_req=1, we=1, addr=1000, wd=0xDEADBEEF; then load from 1000 -> mem_we=1 in the store grant cycle; dm_valid pulses each cycle after grant; load returns dm_rdata=0xDEADBEEF.
3. if_req and dm_req held high together for 12 cycles, MAX_STREAK=4 -> grant pattern D,D,D,D,I repeating; conflict_cnt=12.
4. Store to addr 100, then load from 40000 -> first: mem_we=0, dm_err=1; second: mem_addr=0, dm_rdata=0, dm_err=1; fetch from 800 -> if_err=1, if_rdata=0.
5. Store wd=1 to 33135, then load 33135 with switch=1 -> mem_we=1, mem_addr=33135 passed through; load returns dm_rdata=1, no err.
6. rst driven low asynchronously mid-cycle during a data grant -> all outputs 0 immediately, no dm_valid after release; conflict_cnt restarts at 0.
